// File: rtl/icache_dm2w_if.sv
// Fetch-side and memory-side signals of the instruction cache.
// The slave modport is the cache; the master modport is the datapath/memory side.
interface icache_dm2w_if;
   logic        imemREN;
   logic [31:0] imemaddr;
   logic        ihit;
   logic [31:0] imemload;
   logic        iwait;
   logic        iREN;
   logic [31:0] iaddr;
   logic [31:0] iload;

   modport slave (
      input  imemREN, imemaddr, iwait, iload,
      output ihit, imemload, iREN, iaddr
   );

   modport master (
      output imemREN, imemaddr, iwait, iload,
      input  ihit, imemload, iREN, iaddr
   );
endinterface

// File: rtl/icache_dm2w.sv
// Direct-mapped read-only instruction cache with 2-word blocks and a two-beat miss fill.
// Hits are answered in the request cycle; hit/miss statistics counters saturate.
module icache_dm2w #(
   parameter int unsigned SETS  = 16,
   parameter int unsigned CNT_W = 32
) (
   input  logic             CLK,
   input  logic             nRST,
   icache_dm2w_if.slave     bus,
   output logic [CNT_W-1:0] hit_count,
   output logic [CNT_W-1:0] miss_count
);
   localparam int unsigned IB = $clog2(SETS);
   localparam int unsigned TW = 32 - IB - 3;

   typedef enum logic [1:0] {IDLE, FILL0, FILL1} state_t;

   state_t          state, state_nx;
   logic [SETS-1:0] valid;
   logic [TW-1:0]   tag_arr   [SETS];
   logic [31:0]     data0_arr [SETS];
   logic [31:0]     data1_arr [SETS];

   logic [TW-1:0]   miss_tag;
   logic [IB-1:0]   miss_idx;
   logic            iren_q;
   logic [31:0]     iaddr_q;

   logic [TW-1:0]   req_tag;
   logic [IB-1:0]   req_idx;
   logic            req_word;
   logic            req_hit;

   logic            ihit_c;
   logic [31:0]     load_c;
   logic            ren_nx;
   logic [31:0]     addr_nx;
   logic            start_miss;
   logic            wr0;
   logic            wr1;

   assign req_tag  = bus.imemaddr[31:IB+3];
   assign req_idx  = bus.imemaddr[IB+2:3];
   assign req_word = bus.imemaddr[2];
   assign req_hit  = bus.imemREN && valid[req_idx] && (tag_arr[req_idx] == req_tag);

   // Next state, hit response and next memory request (iREN/iaddr are registered)
   always_comb begin
      state_nx   = state;
      ihit_c     = 1'b0;
      load_c     = 32'h0;
      ren_nx     = 1'b0;
      addr_nx    = 32'h0;
      start_miss = 1'b0;
      wr0        = 1'b0;
      wr1        = 1'b0;
      case (state)
         IDLE: begin
            if (req_hit) begin
               ihit_c = 1'b1;
               load_c = req_word ? data1_arr[req_idx] : data0_arr[req_idx];
            end else if (bus.imemREN) begin
               start_miss = 1'b1;
               state_nx   = FILL0;
               ren_nx     = 1'b1;
               addr_nx    = {req_tag, req_idx, 3'b000};
            end
         end
         FILL0: begin
            ren_nx  = 1'b1;
            addr_nx = {miss_tag, miss_idx, 3'b000};
            if (!bus.iwait) begin
               wr0      = 1'b1;
               state_nx = FILL1;
               addr_nx  = {miss_tag, miss_idx, 3'b100};
            end
         end
         FILL1: begin
            if (!bus.iwait) begin
               wr1      = 1'b1;
               state_nx = IDLE;
            end else begin
               ren_nx  = 1'b1;
               addr_nx = {miss_tag, miss_idx, 3'b100};
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   assign bus.ihit     = ihit_c;
   assign bus.imemload = load_c;
   assign bus.iREN     = iren_q;
   assign bus.iaddr    = iaddr_q;

   // Control state, valid bits and statistics
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state      <= IDLE;
         valid      <= '0;
         miss_tag   <= '0;
         miss_idx   <= '0;
         iren_q     <= 1'b0;
         iaddr_q    <= 32'h0;
         hit_count  <= '0;
         miss_count <= '0;
      end else begin
         state   <= state_nx;
         iren_q  <= ren_nx;
         iaddr_q <= addr_nx;
         if (start_miss) begin
            miss_tag <= req_tag;
            miss_idx <= req_idx;
         end
         if (wr1) valid[miss_idx] <= 1'b1;
         if (ihit_c && (hit_count != '1)) hit_count <= hit_count + CNT_W'(1);
         if (start_miss && (miss_count != '1)) miss_count <= miss_count + CNT_W'(1);
      end
   end

   // Tag and data arrays need no reset; valid bits qualify them
   always_ff @(posedge CLK) begin
      if (wr0) data0_arr[miss_idx] <= bus.iload;
      if (wr1) begin
         data1_arr[miss_idx] <= bus.iload;
         tag_arr[miss_idx]   <= miss_tag;
      end
   end
endmodule

// File: doc/icache_dm2w.md
Name: icache_dm2w

Overview:
- Direct-mapped, read-only instruction cache between the datapath fetch port (imemREN/imemaddr in; ihit/imemload out) and the memory controller's instruction channel.
- Each frame holds a 2-word block. On a miss it runs a two-beat fill from memory, then serves the request from the array.
- Exposes saturating hit/miss counters for end-of-run statistics.

Parameters:
- SETS, 16, number of frames; power of two, minimum 2.
- CNT_W, 32, width of each statistics counter.

Ports:
- CLK  input  1  system clock; all state updates on the rising edge.
- nRST  input  1  asynchronous, active-low reset.
- imemREN  input  1  fetch request from datapath.
- imemaddr  input  32  byte address of the instruction.
- ihit  output  1  requested word is valid on imemload this cycle.
- imemload  output  32  instruction word.
- iwait  input  1  memory busy; 0 means iload is valid this cycle.
- iREN  output  1  read request to memory.
- iaddr  output  32  word-aligned byte address sent to memory.
- iload  input  32  data returned from memory.
- hit_count  output  CNT_W  number of hit cycles.
- miss_count  output  CNT_W  number of misses serviced.

Behaviour:
- Address split, with IB = log2(SETS):
  - [1:0] byte offset, ignored.
  - [2] word within block.
  - [IB+2:3] index.
  - [31:IB+3] tag.
- Per-frame state: valid bit, tag, data0, data1.
- Reset (nRST low, asynchronous):
  - All valid bits cleared; state IDLE; hit_count = miss_count = 0.
  - iREN = 0, iaddr = 0, ihit = 0, imemload = 0.
  - Data and tag arrays need not be cleared.
- FSM states: IDLE, FILL0, FILL1.
- IDLE:
  - Hit when imemREN=1, the indexed frame is valid and its tag matches.
  - On a hit: ihit=1 combinationally in the same cycle; imemload = data0 or data1 selected by addr[2]. Zero-cycle hit latency.
  - On a miss (imemREN=1, not a hit): ihit=0 and imemload=0.
  - Miss handling: at the next edge, latch tag and index into a miss register, increment miss_count, go to FILL0.
  - imemREN=0: ihit=0, imemload=0, iREN=0, iaddr=0, stay in IDLE.
- FILL0:
  - iREN=1; iaddr = {miss_tag, miss_index, 1'b0, 2'b00}.
  - When iwait=0, write iload into data0 of the miss frame at that edge, then go to FILL1. Otherwise hold.
- FILL1:
  - iREN=1; iaddr = {miss_tag, miss_index, 1'b1, 2'b00}.
  - When iwait=0, write iload into data1, write the tag and set valid at that edge, then go to IDLE.
- Service after a fill: the first cycle back in IDLE re-evaluates the request and hits. Miss penalty is 2 + total iwait-high cycles, plus 1 cycle to hit.
- ihit is held 0 in FILL0 and FILL1 regardless of imemREN.
- A fill always completes once started, even if imemREN drops or imemaddr changes mid-fill. The latched miss address is used, never the live imemaddr.
- The valid bit of the frame being filled stays unchanged until the FILL1 completion edge. An evicted frame's old tag is never presented as a hit with partially new data, because ihit=0 throughout the fill.
- Counters:
  - hit_count increments on every cycle with ihit=1.
  - miss_count increments on each IDLE→FILL0 transition.
  - Both saturate at all-ones; no wrap-around.
- Reset asserted mid-fill aborts the fill immediately: state IDLE, valids cleared, iREN=0.
- No writes, no coherence, no invalidate input; the cache is read-only.

Test Plan:
- Reset, then imemREN=1, imemaddr=0x00000000:
  - Miss response: ihit=0 and FILL0 entered.
  - Memory returns 0x11111111 then 0x22222222 with iwait=0: iaddr sequence 0x0, 0x4.
  - Next cycle: ihit=1, imemload=0x11111111; miss_count=1.
- After the previous fill, imemaddr=0x00000004 -> ihit=1 same cycle, imemload=0x22222222; hit_count increments.
- Conflict: SETS=16, so 0x00000000 and 0x00000080 share index 0.
  - Fetch 0x80 -> miss; fill with iaddr 0x80, 0x84.
  - Re-fetch 0x0 -> miss again; miss_count=3.
- Fill with iwait=1 held 5 cycles per beat:
  - iREN=1 and iaddr stable throughout; ihit=0.
  - Hit appears exactly 13 cycles after the miss cycle.
- Mid-fill, imemREN dropped and imemaddr changed to 0x00000100:
  - Fill of the original block completes with the original iaddr values.
  - Then 0x100 misses when requested.
- Reset pulsed during FILL1:
  - iREN=0 immediately; subsequent fetch of the same address misses; counters read 0.
- Hit/miss counters preloaded near saturation (CNT_W=4 build), 20 hits -> hit_count=15.
